// File: rtl/serial_frame_if.sv
// Signal bundle between the raw serial front end and the serial-to-parallel counter stage.
// The master side drives the serial line; the slave side is the frame controller.
interface serial_frame_if #(
   parameter int FCNT_W = 8,
   parameter int ECNT_W = 4
);
   logic              sin;
   logic              in;
   logic              ld_cnt;
   logic [2:0]        init;
   logic              cnt;
   logic              busy;
   logic              done;
   logic              frame_err;
   logic [FCNT_W-1:0] fcnt;
   logic [ECNT_W-1:0] ecnt;

   modport master (
      output sin,
      input  in, ld_cnt, init, cnt, busy, done, frame_err, fcnt, ecnt
   );

   modport slave (
      input  sin,
      output in, ld_cnt, init, cnt, busy, done, frame_err, fcnt, ecnt
   );
endinterface

// File: rtl/serial_frame_ctrl.sv
// Serial frame front end: decodes start/length/data/stop on sin and drives the
// downstream counter stage (in, ld_cnt, init, cnt) plus good/bad frame counters.
module serial_frame_ctrl #(
   parameter int FCNT_W = 8,
   parameter int ECNT_W = 4
) (
   input  logic          clk,
   input  logic          rst,
   serial_frame_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_LEN, S_DATA, S_STOP} state_t;

   state_t            r_state, w_state_next;
   logic [1:0]        r_idx, w_idx_next;
   logic [2:0]        r_len, w_len_next;
   logic [2:0]        r_rem, w_rem_next;
   logic              r_in, w_in_next;
   logic              r_ld_cnt, w_ld_cnt_next;
   logic [2:0]        r_init, w_init_next;
   logic              r_cnt, w_cnt_next;
   logic              r_done, w_done_next;
   logic              r_frame_err, w_frame_err_next;
   logic [FCNT_W-1:0] r_fcnt, w_fcnt_next;
   logic [ECNT_W-1:0] r_ecnt, w_ecnt_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_idx       <= '0;
         r_len       <= '0;
         r_rem       <= '0;
         r_in        <= 1'b0;
         r_ld_cnt    <= 1'b0;
         r_init      <= '0;
         r_cnt       <= 1'b0;
         r_done      <= 1'b0;
         r_frame_err <= 1'b0;
         r_fcnt      <= '0;
         r_ecnt      <= '0;
      end else begin
         r_state     <= w_state_next;
         r_idx       <= w_idx_next;
         r_len       <= w_len_next;
         r_rem       <= w_rem_next;
         r_in        <= w_in_next;
         r_ld_cnt    <= w_ld_cnt_next;
         r_init      <= w_init_next;
         r_cnt       <= w_cnt_next;
         r_done      <= w_done_next;
         r_frame_err <= w_frame_err_next;
         r_fcnt      <= w_fcnt_next;
         r_ecnt      <= w_ecnt_next;
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_idx_next       = r_idx;
      w_len_next       = r_len;
      w_rem_next       = r_rem;
      w_in_next        = r_in;
      w_ld_cnt_next    = 1'b0;
      w_init_next      = r_init;
      w_cnt_next       = 1'b0;
      w_done_next      = 1'b0;
      w_frame_err_next = 1'b0;
      w_fcnt_next      = r_fcnt;
      w_ecnt_next      = r_ecnt;

      case (r_state)
         S_IDLE: begin
            if (!bus.sin) begin
               w_state_next = S_LEN;
               w_idx_next   = '0;
            end
         end
         S_LEN: begin
            w_len_next = {r_len[1:0], bus.sin};
            w_idx_next = r_idx + 2'd1;
            // Third length sample completes the field; load it directly from the shift input.
            if (r_idx == 2'd2) begin
               w_state_next  = S_DATA;
               w_ld_cnt_next = 1'b1;
               w_init_next   = {r_len[1:0], bus.sin};
               w_rem_next    = {r_len[1:0], bus.sin};
            end
         end
         S_DATA: begin
            w_in_next  = bus.sin;
            w_cnt_next = 1'b1;
            w_rem_next = r_rem - 3'd1;
            if (r_rem == 3'd0) begin
               w_state_next = S_STOP;
            end
         end
         S_STOP: begin
            // A zero stop bit ends the frame; it never doubles as the next start bit.
            w_state_next = S_IDLE;
            if (bus.sin) begin
               w_done_next = 1'b1;
               w_fcnt_next = r_fcnt + FCNT_W'(1);
            end else begin
               w_frame_err_next = 1'b1;
               if (r_ecnt != {ECNT_W{1'b1}}) begin
                  w_ecnt_next = r_ecnt + ECNT_W'(1);
               end
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   assign bus.in        = r_in;
   assign bus.ld_cnt    = r_ld_cnt;
   assign bus.init      = r_init;
   assign bus.cnt       = r_cnt;
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.done      = r_done;
   assign bus.frame_err = r_frame_err;
   assign bus.fcnt      = r_fcnt;
   assign bus.ecnt      = r_ecnt;
endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Bench for serial_frame_ctrl: builds a serial stream of directed and random frames,
// derives per-edge expected outputs by parsing the stream frame by frame, and compares every cycle.
module tb_serial_frame_ctrl;
   localparam int NMAX = 4000;

   logic clk = 1'b0;
   logic rst;

   serial_frame_if #(.FCNT_W(8), .ECNT_W(4)) bus ();

   serial_frame_ctrl #(.FCNT_W(8), .ECNT_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Stimulus per edge: sin and rst as seen at that rising edge
   bit sin_q[$];
   bit rst_q[$];
   int n_edges;

   // Expected outputs during the cycle following edge e
   int e_in[NMAX], e_ld[NMAX], e_init[NMAX], e_cnt[NMAX], e_busy[NMAX];
   int e_done[NMAX], e_ferr[NMAX], e_fcnt[NMAX], e_ecnt[NMAX];

   typedef struct {
      int edge_i;
      int sig;
      int val;
   } lit_t;
   lit_t lits[$];

   int n_tests = 0;
   int n_fail  = 0;

   function automatic void push(bit s, bit r = 1'b0);
      sin_q.push_back(s);
      rst_q.push_back(r);
   endfunction

   function automatic void idle(int n);
      for (int i = 0; i < n; i++) push(1'b1);
   endfunction

   // Frame: start, 3 length bits MSB first, L+1 data bits (data[L] sent first), stop
   function automatic int frame(int len, logic [7:0] data, bit stop);
      int s;
      s = sin_q.size();
      push(1'b0);
      for (int b = 2; b >= 0; b--) push(len[b]);
      for (int i = 0; i <= len; i++) push(data[len-i]);
      push(stop);
      return s;
   endfunction

   function automatic void lit(int e, int sig, int v);
      lit_t l;
      l.edge_i = e;
      l.sig    = sig;
      l.val    = v;
      lits.push_back(l);
   endfunction

   function automatic void put(int t, int vin, int ld, int vinit, int cn, int bz,
                               int dn, int fe, int fc, int ec);
      e_in[t]   = vin;
      e_ld[t]   = ld;
      e_init[t] = vinit;
      e_cnt[t]  = cn;
      e_busy[t] = bz;
      e_done[t] = dn;
      e_ferr[t] = fe;
      e_fcnt[t] = fc;
      e_ecnt[t] = ec;
   endfunction

   // Frame-level reference: locate each start bit, read its length, and lay out
   // the whole frame's outputs on the edge timeline, abandoning it on reset.
   function automatic void build_model();
      int cin, cinit, cf, ce, e, k, len, last;
      int ld, cn, dn, fe, bz;
      bit ab;
      cin = 0; cinit = 0; cf = 0; ce = 0; e = 0;
      while (e < n_edges) begin
         if (rst_q[e] || sin_q[e]) begin
            if (rst_q[e]) begin
               cin = 0; cinit = 0; cf = 0; ce = 0;
            end
            put(e, cin, 0, cinit, 0, 0, 0, 0, cf, ce);
            e++;
         end else begin
            k   = e;
            len = (k + 3 < n_edges) ? int'({sin_q[k+1], sin_q[k+2], sin_q[k+3]}) : 0;
            last = k + 5 + len;
            ab  = 1'b0;
            for (int t = k; t <= last && t < n_edges; t++) begin
               if (t > k && rst_q[t]) begin
                  cin = 0; cinit = 0; cf = 0; ce = 0;
                  put(t, 0, 0, 0, 0, 0, 0, 0, 0, 0);
                  e  = t + 1;
                  ab = 1'b1;
                  break;
               end
               ld = 0; cn = 0; dn = 0; fe = 0;
               bz = (t < last) ? 1 : 0;
               if (t == k + 3) begin
                  ld = 1;
                  cinit = len;
               end
               if (t >= k + 4 && t < last) begin
                  cn  = 1;
                  cin = int'(sin_q[t]);
               end
               if (t == last) begin
                  if (sin_q[t]) begin
                     dn = 1;
                     cf = (cf + 1) % 256;
                  end else begin
                     fe = 1;
                     if (ce < 15) ce++;
                  end
               end
               put(t, cin, ld, cinit, cn, bz, dn, fe, cf, ce);
            end
            if (!ab) e = last + 1;
         end
      end
   endfunction

   function automatic int dut_sig(int sig);
      case (sig)
         0: return int'(bus.ld_cnt);
         1: return int'(bus.init);
         2: return int'(bus.in);
         3: return int'(bus.cnt);
         4: return int'(bus.busy);
         5: return int'(bus.done);
         6: return int'(bus.frame_err);
         7: return int'(bus.fcnt);
         default: return int'(bus.ecnt);
      endcase
   endfunction

   function automatic int model_sig(int sig, int e);
      case (sig)
         0: return e_ld[e];
         1: return e_init[e];
         2: return e_in[e];
         3: return e_cnt[e];
         4: return e_busy[e];
         5: return e_done[e];
         6: return e_ferr[e];
         7: return e_fcnt[e];
         default: return e_ecnt[e];
      endcase
   endfunction

   function automatic string sig_name(int sig);
      case (sig)
         0: return "ld_cnt";
         1: return "init";
         2: return "in";
         3: return "cnt";
         4: return "busy";
         5: return "done";
         6: return "frame_err";
         7: return "fcnt";
         default: return "ecnt";
      endcase
   endfunction

   task automatic chk(string nm, int e, int act, int exp_v);
      n_tests++;
      if (act != exp_v) begin
         n_fail++;
         if (n_fail <= 40)
            $display("[TB] FAIL %s edge %0d: got %0d expected %0d", nm, e, act, exp_v);
      end
   endtask

   task automatic check_edge(int e);
      int a;
      for (int s = 0; s < 9; s++) begin
         a = dut_sig(s);
         // in is only meaningful once a frame has delivered data or after reset
         chk(sig_name(s), e, a, model_sig(s, e));
      end
      foreach (lits[i]) begin
         if (lits[i].edge_i == e) begin
            chk({"lit_", sig_name(lits[i].sig)}, e, dut_sig(lits[i].sig), lits[i].val);
            chk({"model_", sig_name(lits[i].sig)}, e, model_sig(lits[i].sig, e), lits[i].val);
         end
      end
      if (e_done[e] == 1 || e_ferr[e] == 1)
         $display("[TB] edge %0d frame end done=%0d err=%0d fcnt=%0d ecnt=%0d",
                  e, bus.done, bus.frame_err, bus.fcnt, bus.ecnt);
   endtask

   task automatic build_stimulus();
      int s, b, len, cut, last_len;
      logic [7:0] d;
      bit stop;

      // Reset held two edges with the line low
      push(1'b0, 1'b1);
      push(1'b0, 1'b1);
      for (int sg = 0; sg < 9; sg++) lit(1, sg, 0);
      idle(5);
      lit(6, 4, 0);
      lit(6, 3, 0);

      // Nominal L=5, data 110010
      s = frame(5, 8'b0011_0010, 1'b1);
      lit(s + 2, 0, 0);
      lit(s + 3, 0, 1);
      lit(s + 3, 1, 5);
      lit(s + 3, 3, 0);
      lit(s + 4, 2, 1); lit(s + 5, 2, 1); lit(s + 6, 2, 0);
      lit(s + 7, 2, 0); lit(s + 8, 2, 1); lit(s + 9, 2, 0);
      lit(s + 4, 3, 1); lit(s + 9, 3, 1); lit(s + 10, 3, 0);
      lit(s + 10, 5, 1); lit(s + 10, 7, 1); lit(s + 10, 4, 0);
      lit(s + 9, 4, 1); lit(s + 0, 4, 1);

      // Maximum length L=7, data 10110010
      s = frame(7, 8'b1011_0010, 1'b1);
      lit(s + 3, 1, 7);
      lit(s + 4, 2, 1); lit(s + 5, 2, 0); lit(s + 6, 2, 1); lit(s + 7, 2, 1);
      lit(s + 8, 2, 0); lit(s + 9, 2, 0); lit(s + 10, 2, 1); lit(s + 11, 2, 0);
      lit(s + 11, 3, 1); lit(s + 12, 3, 0);
      lit(s + 12, 5, 1); lit(s + 12, 7, 2);

      // Minimum length L=0, data 1
      s = frame(0, 8'b0000_0001, 1'b1);
      lit(s + 3, 1, 0);
      lit(s + 4, 3, 1); lit(s + 4, 2, 1);
      lit(s + 5, 3, 0); lit(s + 5, 5, 1); lit(s + 5, 7, 3);

      // Framing error then idle: the zero stop bit must not start a frame
      s = frame(2, 8'b0000_0011, 1'b0);
      idle(4);
      lit(s + 7, 6, 1); lit(s + 7, 8, 1); lit(s + 7, 7, 3); lit(s + 7, 5, 0);
      lit(s + 8, 4, 0); lit(s + 10, 0, 0); lit(s + 10, 4, 0);

      // Sixteen more bad frames drive the error counter into saturation
      last_len = 0;
      s = 0;
      for (int i = 0; i < 16; i++) begin
         last_len = $urandom_range(0, 7);
         s = frame(last_len, 8'($urandom), 1'b0);
         idle(1);
      end
      lit(s + 5 + last_len, 8, 15);
      lit(s + 5 + last_len, 6, 1);

      // Back-to-back L=1 frames
      b = frame(1, 8'b0000_0010, 1'b1);
      s = frame(1, 8'b0000_0001, 1'b1);
      idle(3);
      lit(b + 3, 0, 1); lit(b + 10, 0, 1); lit(b + 9, 0, 0);
      lit(b + 5, 4, 1); lit(b + 6, 4, 0); lit(b + 7, 4, 1);
      lit(b + 6, 5, 1); lit(b + 13, 5, 1); lit(b + 13, 7, 5);
      lit(b + 11, 2, 0); lit(b + 4, 2, 1);

      // Reset during the 3rd data bit of an L=6 frame, then a normal frame
      s = sin_q.size();
      push(1'b0);
      push(1'b1); push(1'b1); push(1'b0);
      push(1'b1); push(1'b0); push(1'b1, 1'b1);
      idle(3);
      lit(s + 5, 3, 1); lit(s + 5, 4, 1);
      lit(s + 6, 3, 0); lit(s + 6, 4, 0); lit(s + 6, 5, 0);
      lit(s + 6, 7, 0); lit(s + 6, 8, 0); lit(s + 6, 1, 0);
      s = frame(3, 8'b0000_1001, 1'b1);
      lit(s + 3, 1, 3); lit(s + 8, 5, 1); lit(s + 8, 7, 1);

      // Random traffic: gaps, bad stops and occasional mid-frame resets
      for (int i = 0; i < 70; i++) begin
         len  = $urandom_range(0, 7);
         d    = 8'($urandom);
         stop = ($urandom_range(0, 4) != 0);
         s = frame(len, d, stop);
         if ($urandom_range(0, 12) == 0) begin
            cut = $urandom_range(1, len + 5);
            while (sin_q.size() > s + cut + 1) begin
               void'(sin_q.pop_back());
               void'(rst_q.pop_back());
            end
            rst_q[s + cut] = 1'b1;
            idle(4);
         end else begin
            idle($urandom_range(0, 3));
         end
      end
      idle(8);
   endtask

   initial begin
      rst     = 1'b1;
      bus.sin = 1'b1;
      build_stimulus();
      n_edges = sin_q.size();
      if (n_edges > NMAX) begin
         $display("[TB] FAIL stimulus_size: got %0d expected at most %0d", n_edges, NMAX);
         $fatal(1, "stimulus too long");
      end
      build_model();

      @(negedge clk);
      fork
         begin
            for (int e = 0; e < n_edges; e++) begin
               bus.sin = sin_q[e];
               rst     = rst_q[e];
               @(negedge clk);
            end
            rst     = 1'b0;
            bus.sin = 1'b1;
         end
         begin
            for (int e = 0; e < n_edges; e++) begin
               @(posedge clk);
               #1;
               check_edge(e);
            end
         end
      join

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/serial_frame_ctrl.md
# serial_frame_ctrl

Front-end controller placed directly upstream of the serial-to-parallel counter stage. It watches a raw serial line, decodes a start bit and a 3-bit length field, then drives the downstream stage's serial data, `ld_cnt`, `init` and `cnt` inputs for exactly the announced number of data bits. It also checks the stop bit and counts good and bad frames.

## Interface
- `FCNT_W`, default 8: width of the good-frame counter.
- `ECNT_W`, default 4: width of the saturating error counter.

- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `sin`  input  1  raw serial line; idles at 1.
- `in`  output  1  registered data bit to the downstream `in` port.
- `ld_cnt`  output  1  one-cycle load strobe to the downstream counter.
- `init`  output  3  length value (N−1) to load; valid while `ld_cnt`=1 and held until the next load.
- `cnt`  output  1  count enable; high in every cycle in which `in` carries a data bit.
- `busy`  output  1  high whenever state ≠ IDLE.
- `done`  output  1  one-cycle pulse when a frame ends with a valid stop bit.
- `frame_err`  output  1  one-cycle pulse when the stop bit is 0.
- `fcnt`  output  FCNT_W  good-frame count; wraps modulo 2^FCNT_W.
- `ecnt`  output  ECNT_W  error count; saturates at all-ones.

## Operation
- **Frame format on `sin`** (one bit per clock, sampled at the rising edge):
  - start bit = 0
  - 3 length bits, MSB first; value L gives N = L+1 data bits (1..8)
  - N data bits
  - stop bit = 1
- **FSM states:** IDLE, LEN, DATA, STOP.
- **IDLE:** if `sin`=0, go to LEN and clear the bit index. Otherwise stay.
- **LEN:** shift `sin` into `len[2:0]`, MSB first.
  - On the 3rd length sample: go to DATA, register `ld_cnt`←1, `init`←full captured length, `rem`←captured length.
- **DATA:** register `in`←`sin` and `cnt`←1 on each sample.
  - `rem` decrements on each sample.
  - The sample taken when `rem`=0 is the last data bit; go to STOP.
- **STOP:** sample `sin`.
  - If 1: `done`←1 and `fcnt`←`fcnt`+1.
  - If 0: `frame_err`←1 and `ecnt`←min(`ecnt`+1, max).
  - Always return to IDLE. A 0 stop bit is never reinterpreted as a start bit.
- **Output defaults:** `ld_cnt`, `cnt`, `done` and `frame_err` are 0 in every cycle not listed above.
- **`in` outside data cycles:** `in` holds its last value; downstream qualifies it with `cnt`.
- **Reset values:** on `rst`=1 at an edge, the state goes to IDLE and all outputs become 0. This includes `init`, `fcnt` and `ecnt`. `len` and `rem` are cleared.
- **Reset mid-frame:** the frame is abandoned, with no `done` and no `frame_err`.

## Timing
- Let edge k be the edge that samples the start bit.
  - Edges k+1..k+3 sample length bits.
  - `ld_cnt`=1 during cycle (k+3, k+4).
  - `cnt`=1 with valid `in` during cycles (k+4+i, k+5+i) for i = 0..L.
  - Edge k+5+L samples the stop bit.
  - `done` or `frame_err` is high during cycle (k+5+L, k+6+L); `cnt`=0 in that cycle.
- **Latency:** each data bit appears on `in` one cycle after it is on `sin`.
- **Frame length:** L+6 cycles, including start and stop.
- **Back-to-back frames:** the edge right after the stop sample (k+6+L) may sample a new start bit. `ld_cnt` of the new frame then follows the previous `done` with no gap beyond the frame structure.
- **`busy`:** 1 from cycle (k, k+1) through cycle (k+5+L, k+6+L) exclusive, i.e. it falls in the same cycle that `done` or `frame_err` rises.
- `ld_cnt` and `cnt` are never high in the same cycle.

## Test plan
- **Reset:** hold `rst`=1 for 2 cycles while `sin`=0 → all outputs 0, state IDLE. After release with `sin`=1 for 5 cycles → no activity.
- **Nominal frame, L=5:** `sin` = 0, 1,0,1, 1,1,0,0,1,0, 1 →
  - `ld_cnt` for one cycle with `init`=3'b101;
  - `cnt` high for 6 consecutive cycles with `in` = 1,1,0,0,1,0;
  - `done` pulse, `fcnt`=1.
- **Minimum and maximum length:**
  - L=0 with data 1 → one `cnt` cycle, `in`=1, `done`.
  - L=7 with data 10110010 → 8 `cnt` cycles carrying those bits, `done`, `fcnt`=2.
- **Framing error:** L=2, data 011, stop=0, then `sin`=1 → `frame_err` pulse, `ecnt`=1, `fcnt` unchanged, no new frame started.
  - After 16 more bad frames, `ecnt` stays at 4'hF.
- **Back-to-back frames:** two L=1 frames with no idle gap → two `ld_cnt` pulses 7 cycles apart, two `done` pulses, `busy` low for exactly the one `done` cycle between them.
- **Reset mid-operation:** assert `rst` during the 3rd data bit of an L=6 frame → next cycle `cnt`=0 and `busy`=0, no `done`. A following valid frame is received normally.
